clm_digit_multiplier: RTL and testbench
=======================================

# clm_digit_multiplier

Digit-serial multiplier over GF(2^K) in the lifted (CLM) redundant representation: operands and result are N = K+D bit polynomials congruent mod P. Each cycle it consumes W bits of p1, reduces by a fresh random multiple of P, and refreshes the accumulator with a random multiple of P. Randomness is streamed per cycle under a valid handshake. It replaces the bit-serial multiplier in the masked S-box/MixColumns datapath and adds a squaring mode.

## Interface
- K, 8, base field degree (P monic, degree K)
- D, 4, redundancy degree; N = K+D
- W, 2, digit width (bits of p1 per cycle), 1 <= W <= N
- C (localparam), ceil(N/W), RUN cycles per operation
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- P  in  K  low K coefficients of P (x^K implicit)
- start  in  1  operation request (drdy_i role)
- sq  in  1  1: compute p1*p1, p2 ignored; sampled with start
- refresh_en  in  1  1: apply per-cycle accumulator refresh; sampled with start
- p1, p2  in  N  operands, bit i = coefficient of x^i
- rnd_q  in  W*D  W reduction masks q_j (slice j = bits j*D+:D), one per sub-step
- rnd_r  in  D  refresh mask r
- rnd_valid  in  1  randomness valid this cycle
- rnd_ready  out  1  randomness consumed this cycle (= RUN & rnd_valid)
- busy  out  1  high in RUN and DONE
- drdy_o  out  1  one-cycle result strobe
- out  out  N  result register

## Operation
- States IDLE, RUN, DONE. Registers: acc (N), sh (N), a (C*W, p1 zero-extended), cnt (clog2 C), sq/refresh flags, state.
- IDLE/DONE + start: a <- p1, sh <- (sq ? p1 : p2), acc <- 0, cnt <- 0, latch flags, -> RUN. start in RUN ignored.
- RUN, rnd_valid=1: W combinational sub-steps j = 0..W-1, bit b = a[cnt*W+j]:
  - acc_j+1 = acc_j ^ (b ? sh_j : 0)
  - PQ_j = clmul(P_full, x^D ^ q_j) with x^N term dropped (N bits) = clmul(P_full, q_j) ^ (P << D)
  - sh_j+1 = (sh_j << 1)[N-1:0] ^ (sh_j[N-1] ? PQ_j : 0)
  - after sub-steps: acc <- acc_W ^ (refresh ? clmul(P_full, r) : 0); sh <- sh_W; cnt++.
- RUN, rnd_valid=0: stall, all registers hold, rnd_ready=0.
- RUN, cnt=C-1, rnd_valid=1: out <- final acc, -> DONE.
- DONE: drdy_o=1 one cycle; -> IDLE, or RUN if start.
- Invariant: out mod P = (p1*p2 mod P) (or p1^2), for any random stream.
- Padding bits of a (indices >= N) are 0; their sub-steps still shift sh, no effect on result.
- out holds until next DONE; not cleared by start.

## Timing
- Reset (rst=0, async): state=IDLE, acc, sh, a, cnt, out = 0, busy=0, drdy_o=0, rnd_ready=0. Reset mid-RUN aborts; no drdy_o follows.
- start sampled at edge t -> RUN during cycles t+1..t+C (no stalls) -> drdy_o and new out visible cycle t+C+1. Each stall cycle adds exactly 1.
- Back-to-back: start during DONE gives next drdy_o C+1 cycles later; throughput one op per C+1 cycles.
- Randomness consumed only on cycles with rnd_ready=1; exactly C draws per operation.
- All outputs registered except rnd_ready (combinational from state, rnd_valid).

## Test plan
- K=8,D=4,W=2,P=0x1B, rnd all 0, refresh off, p1=0x053, p2=0x0CA -> drdy_o 7 cycles after start; out mod 0x11B = 0x01.
- Same operands, LFSR random stream, refresh on; plus 1000 random operand/random vectors vs reference model -> bit-exact out vs model, out mod P matches AES product.
- sq=1, p1=0x080, p2=0xFFF -> out mod P = 0x9A; p1=0x002 -> 0x04.
- rnd_valid low 3 cycles at cnt=2 -> drdy_o exactly 3 cycles late, out identical to unstalled run with same draws; rnd_ready low during stall.
- start in DONE cycle -> second drdy_o 7 cycles later; start pulsed in RUN -> ignored, operands unchanged.
- rst low at cnt=3 -> busy, drdy_o, out = 0 immediately; after release IDLE, no drdy_o until new start; W=1 and W=3 (C=12, C=4) rerun scenario 1.

Source files
------------

// File: rtl/clm_digit_multiplier.sv
// Digit-serial GF(2^K) multiplier on lifted (K+D)-bit redundant polynomials.
// Each RUN cycle folds W bits of p1 into acc, reducing sh by random multiples of P.
module clm_digit_step #(
  parameter int K = 8,
  parameter int D = 4,
  localparam int N = K + D
) (
  input  logic [K-1:0] p,
  input  logic [D-1:0] q,
  input  logic         b,
  input  logic [N-1:0] acc_in,
  input  logic [N-1:0] sh_in,
  output logic [N-1:0] acc_out,
  output logic [N-1:0] sh_out
);
  logic [N-1:0] pfull;
  logic [N-1:0] pq;

  assign pfull = N'({1'b1, p});

  // pq = P*(x^D + q) with the x^N term dropped; cancels the bit shifted out of sh
  always_comb begin
    pq = pfull << D;
    for (int i = 0; i < D; i++)
      if (q[i]) pq = pq ^ (pfull << i);
  end

  assign acc_out = b ? (acc_in ^ sh_in) : acc_in;
  assign sh_out  = (sh_in << 1) ^ (sh_in[N-1] ? pq : '0);
endmodule

module clm_digit_multiplier #(
  parameter int K = 8,
  parameter int D = 4,
  parameter int W = 2,
  localparam int N = K + D,
  localparam int C = (N + W - 1) / W,
  localparam int CNT_W = (C > 1) ? $clog2(C) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [K-1:0]   P,
  input  logic           start,
  input  logic           sq,
  input  logic           refresh_en,
  input  logic [N-1:0]   p1,
  input  logic [N-1:0]   p2,
  input  logic [W*D-1:0] rnd_q,
  input  logic [D-1:0]   rnd_r,
  input  logic           rnd_valid,
  output logic           rnd_ready,
  output logic           busy,
  output logic           drdy_o,
  output logic [N-1:0]   out
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [N-1:0]     acc, sh;
  logic [C*W-1:0]   a;
  logic [CNT_W-1:0] cnt;
  logic             refresh_f;

  logic [W:0][N-1:0] acc_c, sh_c;
  logic [N-1:0]      pfull, rmask, acc_nxt;
  logic              cnt_last;

  assign acc_c[0] = acc;
  assign sh_c[0]  = sh;

  // a is consumed low digit first and shifted down, so a[j] is always bit cnt*W+j
  for (genvar j = 0; j < W; j++) begin : g_step
    clm_digit_step #(.K(K), .D(D)) u_step (
      .p      (P),
      .q      (rnd_q[j*D +: D]),
      .b      (a[j]),
      .acc_in (acc_c[j]),
      .sh_in  (sh_c[j]),
      .acc_out(acc_c[j+1]),
      .sh_out (sh_c[j+1])
    );
  end

  assign pfull = N'({1'b1, P});

  always_comb begin
    rmask = '0;
    for (int i = 0; i < D; i++)
      if (rnd_r[i]) rmask = rmask ^ (pfull << i);
  end

  assign acc_nxt   = acc_c[W] ^ (refresh_f ? rmask : '0);
  assign cnt_last  = (cnt == CNT_W'(C - 1));
  assign rnd_ready = (state == RUN) & rnd_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      sh        <= '0;
      a         <= '0;
      cnt       <= '0;
      refresh_f <= 1'b0;
      busy      <= 1'b0;
      drdy_o    <= 1'b0;
      out       <= '0;
    end else begin
      drdy_o <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a         <= (C*W)'(p1);
            sh        <= sq ? p1 : p2;
            acc       <= '0;
            cnt       <= '0;
            refresh_f <= refresh_en;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (rnd_valid) begin
            acc <= acc_nxt;
            sh  <= sh_c[W];
            a   <= a >> W;
            cnt <= cnt + CNT_W'(1);
            if (cnt_last) begin
              out    <= acc_nxt;
              drdy_o <= 1'b1;
              state  <= DONE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_clm_digit_multiplier.sv
// Self-checking bench: directed table, hand sequences (reset abort, W=1/3) and random ops vs model.
module tb_clm_digit_multiplier;
  localparam int K = 8, D = 4, N = 12, C = 6;
  localparam logic [7:0] PL = 8'h1B;
  localparam longint PFULL = 64'h11B;
  localparam longint MASKN = (64'd1 << N) - 1;

  logic clk = 0, rst = 0;
  logic start = 0, sq = 0, refresh_en = 0, rnd_valid = 0;
  logic [N-1:0] p1 = 0, p2 = 0;
  logic [7:0] rnd_q = 0;
  logic [3:0] rnd_q1 = 0;
  logic [11:0] rnd_q3 = 0;
  logic [D-1:0] rnd_r = 0;
  logic rnd_ready, busy, drdy_o;
  logic [N-1:0] out;
  logic rdy1, busy1, drdy1, rdy3, busy3, drdy3;
  logic [N-1:0] out1, out3;

  int n_vec = 0, n_bad = 0;
  int q_draw[C], r_draw[C];
  logic [15:0] lfsr = 16'hACE1;

  typedef struct {
    logic [N-1:0] p1, p2;
    bit sq, rf;
    int rmode;       // 0 zero, 1 lfsr, 2 urandom
    int stall_at, stall_len, poke_at;
    bit chk_mod;
    logic [7:0] exp_mod;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  clm_digit_multiplier #(.K(K), .D(D), .W(2)) u_dut (
    .clk(clk), .rst(rst), .P(PL), .start(start), .sq(sq), .refresh_en(refresh_en),
    .p1(p1), .p2(p2), .rnd_q(rnd_q), .rnd_r(rnd_r), .rnd_valid(rnd_valid),
    .rnd_ready(rnd_ready), .busy(busy), .drdy_o(drdy_o), .out(out));
  clm_digit_multiplier #(.K(K), .D(D), .W(1)) u_w1 (
    .clk(clk), .rst(rst), .P(PL), .start(start), .sq(sq), .refresh_en(refresh_en),
    .p1(p1), .p2(p2), .rnd_q(rnd_q1), .rnd_r(rnd_r), .rnd_valid(rnd_valid),
    .rnd_ready(rdy1), .busy(busy1), .drdy_o(drdy1), .out(out1));
  clm_digit_multiplier #(.K(K), .D(D), .W(3)) u_w3 (
    .clk(clk), .rst(rst), .P(PL), .start(start), .sq(sq), .refresh_en(refresh_en),
    .p1(p1), .p2(p2), .rnd_q(rnd_q3), .rnd_r(rnd_r), .rnd_valid(rnd_valid),
    .rnd_ready(rdy3), .busy(busy3), .drdy_o(drdy3), .out(out3));

  function automatic longint clmul(longint x, longint y);
    longint r = 0;
    for (int i = 0; i < 32; i++) if (y[i]) r ^= x << i;
    return r;
  endfunction

  function automatic longint polymod(longint v);
    for (int i = 40; i >= K; i--) if (v[i]) v ^= PFULL << (i - K);
    return v;
  endfunction

  // Reference: p1 scanned LSB first, C*W bits; shifted multiplicand reduced by P*(x^D+q).
  function automatic longint model(longint a, longint b, bit s, bit rf);
    longint acc = 0, sh = s ? a : b, q;
    bit top;
    for (int c = 0; c < C; c++) begin
      for (int j = 0; j < 2; j++) begin
        int i = c * 2 + j;
        if (i < N && ((a >> i) & 1) == 1) acc ^= sh;
        top = ((sh >> (N - 1)) & 1) == 1;
        sh = (sh << 1) & MASKN;
        q = (longint'(q_draw[c]) >> (j * D)) & 15;
        if (top) sh ^= clmul(PFULL, 16 | q) & MASKN;
      end
      if (rf) acc ^= clmul(PFULL, longint'(r_draw[c]));
    end
    return acc;
  endfunction

  task automatic check(input string name, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fill_draws(input int mode);
    for (int c = 0; c < C; c++) begin
      case (mode)
        0: begin q_draw[c] = 0; r_draw[c] = 0; end
        1: begin
          for (int s = 0; s < 12; s++) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
          q_draw[c] = int'(lfsr[7:0]); r_draw[c] = int'(lfsr[11:8]);
        end
        default: begin q_draw[c] = int'($urandom & 'hFF); r_draw[c] = int'($urandom & 'hF); end
      endcase
    end
  endtask

  // Entered and left at a negedge; leaves the DUT in its DONE cycle.
  task automatic run_op(input vec_t v);
    int idx = 0, lat = 1, stall_left;
    bit rdy_ok = 1, done = 0, valid;
    longint exp_out, exp_mod, pb;
    fill_draws(v.rmode);
    p1 = v.p1; p2 = v.p2; sq = v.sq; refresh_en = v.rf; start = 1; rnd_valid = 0;
    @(negedge clk);
    start = 0;
    stall_left = v.stall_len;
    while (lat <= C + 1 + v.stall_len + 4) begin
      if (drdy_o) begin done = 1; break; end
      valid = 1;
      if (idx == v.stall_at && stall_left > 0) begin valid = 0; stall_left--; end
      rnd_valid = valid;
      rnd_q = (idx < C) ? 8'(q_draw[idx]) : 8'h0;
      rnd_r = (idx < C) ? 4'(r_draw[idx]) : 4'h0;
      if (idx == v.poke_at && valid) begin
        start = 1; p1 = ~v.p1; p2 = ~v.p2; sq = ~v.sq;
      end else begin
        start = 0; p1 = v.p1; p2 = v.p2; sq = v.sq;
      end
      #1;
      if (rnd_ready !== valid || busy !== 1'b1) rdy_ok = 0;
      @(negedge clk);
      if (valid) idx++;
      lat++;
    end
    start = 0; rnd_valid = 0; p1 = v.p1; p2 = v.p2; sq = v.sq;
    if (!done) lat = -1;
    exp_out = model(longint'(v.p1), longint'(v.p2), v.sq, v.rf);
    pb = v.sq ? longint'(v.p1) : longint'(v.p2);
    exp_mod = v.chk_mod ? longint'(v.exp_mod) : polymod(clmul(longint'(v.p1), pb));
    check("latency", lat, C + 1 + v.stall_len);
    check("out_exact", longint'(out), exp_out);
    check("out_mod_p", polymod(longint'(out)), exp_mod);
    check("rnd_ready_busy", longint'(rdy_ok), 1);
  endtask

  initial begin
    int l2, l1, l3;
    bit quiet;
    vec_t rv;
    tbl[0] = '{12'h053, 12'h0CA, 0, 0, 0, -1, 0, -1, 1, 8'h01};
    tbl[1] = '{12'h053, 12'h0CA, 0, 1, 1, -1, 0, -1, 1, 8'h01};
    tbl[2] = '{12'h080, 12'hFFF, 1, 1, 2, -1, 0, -1, 1, 8'h9A};
    tbl[3] = '{12'h002, 12'hFFF, 1, 1, 1, -1, 0, -1, 1, 8'h04};
    tbl[4] = '{12'h053, 12'h0CA, 0, 1, 2, 2, 3, -1, 1, 8'h01};
    tbl[5] = '{12'h9C7, 12'h3A5, 0, 1, 2, -1, 0, 3, 0, 8'h00};

    // reset state
    rnd_valid = 1;
    #12;
    check("rst_busy", longint'(busy), 0);
    check("rst_drdy", longint'(drdy_o), 0);
    check("rst_out", longint'(out), 0);
    check("rst_rnd_ready", longint'(rnd_ready), 0);
    @(negedge clk); rst = 1; rnd_valid = 0;

    // scenario 1 on W=2, W=1, W=3 together with zero randomness
    p1 = 12'h053; p2 = 12'h0CA; sq = 0; refresh_en = 0; start = 1;
    @(negedge clk); start = 0; rnd_valid = 1;
    l2 = -1; l1 = -1; l3 = -1;
    for (int t = 1; t <= 16; t++) begin
      if (drdy_o && l2 < 0) l2 = t;
      if (drdy1 && l1 < 0) l1 = t;
      if (drdy3 && l3 < 0) l3 = t;
      if (l1 > 0 && l2 > 0 && l3 > 0) break;
      @(negedge clk);
    end
    rnd_valid = 0;
    check("w2_latency", l2, 7);
    check("w1_latency", l1, 13);
    check("w3_latency", l3, 5);
    check("w2_mod", polymod(longint'(out)), 1);
    check("w1_mod", polymod(longint'(out1)), 1);
    check("w3_mod", polymod(longint'(out3)), 1);
    repeat (3) @(negedge clk);

    // directed table, back-to-back (each start lands in the previous DONE cycle)
    foreach (tbl[i]) run_op(tbl[i]);

    // reset at cnt=3 aborts the operation
    p1 = 12'h053; p2 = 12'h0CA; sq = 0; refresh_en = 1; start = 1;
    @(negedge clk); start = 0; rnd_valid = 1; rnd_q = 8'h5A; rnd_r = 4'h3;
    repeat (3) @(negedge clk);
    rst = 0; #1;
    check("abort_busy", longint'(busy), 0);
    check("abort_drdy", longint'(drdy_o), 0);
    check("abort_out", longint'(out), 0);
    @(negedge clk); rst = 1;
    quiet = 1;
    repeat (10) begin
      @(negedge clk);
      if (drdy_o || busy) quiet = 0;
    end
    rnd_valid = 0;
    check("abort_quiet", longint'(quiet), 1);

    // random operations
    for (int n = 0; n < 1000; n++) begin
      rv.p1 = 12'($urandom); rv.p2 = 12'($urandom);
      rv.sq = ($urandom_range(0, 3) == 0); rv.rf = 1'($urandom);
      rv.rmode = 2;
      rv.stall_at = $urandom_range(0, C - 1);
      rv.stall_len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      rv.poke_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, C - 1) : -1;
      rv.chk_mod = 0; rv.exp_mod = 0;
      run_op(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
